// File: rtl/pipe_stage_buf.sv
// ----------------------------------------------------------------------------
// pipe_stage_buf
//   Inter-stage pipeline buffer with a valid/ready handshake, an optional
//   2-entry skid buffer for stall back-pressure, and a synchronous flush that
//   turns held entries into bubbles. The stage payload is packed by the
//   instantiating stage into in_data.
//
// Parameters
//   DATA_W    payload width in bits
//   NOP_VALUE payload driven on out_data whenever out_valid=0
//   SKID      1: two entries (main + skid), registered in_ready
//             0: one entry, in_ready combinational from out_ready
//   CNT_W     width of the saturating stall-cycle counter
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   upstream presents a beat
//   in_ready   buffer can accept a beat this cycle
//   in_data    upstream payload
//   flush      kill every held entry at the next edge
//   out_valid  head entry valid toward downstream
//   out_ready  downstream accepts head this cycle
//   out_data   head payload, or NOP_VALUE when out_valid=0
//   occupancy  number of held entries
//   stall_cnt  cycles with out_valid=1 and out_ready=0, saturating
// ----------------------------------------------------------------------------
module pipe_stage_buf #(
    parameter int unsigned        DATA_W    = 133,
    parameter logic [DATA_W-1:0]  NOP_VALUE = '0,
    parameter int unsigned        SKID      = 1,
    parameter int unsigned        CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // State encoding equals the number of held entries.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e            r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              r_in_ready;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_push;
    logic w_pop;
    logic w_stall;

    assign out_valid = (r_state != StEmpty);
    assign out_data  = out_valid ? r_main : NOP_VALUE;
    assign occupancy = r_state;
    assign stall_cnt = r_stall_cnt;

    // Without the skid entry the only way to accept while full is to have
    // downstream drain the entry in the same cycle.
    assign in_ready = (SKID != 0) ? r_in_ready : ((r_state == StEmpty) || out_ready);

    assign w_push  = in_valid & in_ready;
    assign w_pop   = out_valid & out_ready;
    assign w_stall = out_valid & ~out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StEmpty;
            r_main      <= NOP_VALUE;
            r_skid      <= NOP_VALUE;
            r_in_ready  <= 1'b1;
            r_stall_cnt <= '0;
        end else begin
            if (w_stall && !flush && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end

            if (flush) begin
                // Any same-cycle push is dropped; a same-cycle pop has already
                // been taken by downstream.
                r_state    <= StEmpty;
                r_in_ready <= 1'b1;
            end else begin
                unique case (r_state)
                    StEmpty: begin
                        if (w_push) begin
                            r_main  <= in_data;
                            r_state <= StOne;
                        end
                    end
                    StOne: begin
                        if (w_push && w_pop) begin
                            r_main <= in_data;
                        end else if (w_push && (SKID != 0)) begin
                            r_skid     <= in_data;
                            r_state    <= StTwo;
                            r_in_ready <= 1'b0;
                        end else if (w_pop) begin
                            r_state <= StEmpty;
                        end
                    end
                    StTwo: begin
                        // Skid entry moves up behind the popped head: FIFO order.
                        if (w_pop) begin
                            r_main     <= r_skid;
                            r_state    <= StOne;
                            r_in_ready <= 1'b1;
                        end
                    end
                    default: begin
                        r_state    <= StEmpty;
                        r_in_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_buf
//   Drives three instances from shared stimulus: SKID=1 (CNT_W=16), SKID=0,
//   and SKID=1 with CNT_W=4. Each is compared every cycle against a queue
//   reference model.
// ----------------------------------------------------------------------------
module tb_pipe_stage_buf;

    localparam int unsigned DATA_W = 133;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_ready;

    logic              a_in_ready, b_in_ready, s_in_ready;
    logic              a_out_valid, b_out_valid, s_out_valid;
    logic [DATA_W-1:0] a_out_data, b_out_data, s_out_data;
    logic [1:0]        a_occ, b_occ, s_occ;
    logic [15:0]       a_cnt, b_cnt;
    logic [3:0]        s_cnt;

    pipe_stage_buf #(.DATA_W(DATA_W), .SKID(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .occupancy(a_occ), .stall_cnt(a_cnt)
    );

    pipe_stage_buf #(.DATA_W(DATA_W), .SKID(0), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .occupancy(b_occ), .stall_cnt(b_cnt)
    );

    pipe_stage_buf #(.DATA_W(DATA_W), .SKID(1), .CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .occupancy(s_occ), .stall_cnt(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference state: FIFO contents and plain stall totals.
    logic [DATA_W-1:0] qa[$];
    logic [DATA_W-1:0] qb[$];
    int unsigned       cnt_a, cnt_b, cnt_s;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] head_a();
        return (qa.size() > 0) ? qa[0] : '0;
    endfunction

    function automatic logic [DATA_W-1:0] head_b();
        return (qb.size() > 0) ? qb[0] : '0;
    endfunction

    task automatic model_clear();
        qa.delete();
        qb.delete();
        cnt_a = 0;
        cnt_b = 0;
        cnt_s = 0;
    endtask

    task automatic compare_all();
        check_eq("a_valid", 256'(a_out_valid), 256'(qa.size() > 0));
        check_eq("a_data",  256'(a_out_data),  256'(head_a()));
        check_eq("a_ready", 256'(a_in_ready),  256'(qa.size() < 2));
        check_eq("a_occ",   256'(a_occ),       256'(qa.size()));
        check_eq("a_cnt",   256'(a_cnt),       256'(cnt_a));
        check_eq("s_data",  256'(s_out_data),  256'(head_a()));
        check_eq("s_occ",   256'(s_occ),       256'(qa.size()));
        check_eq("s_cnt",   256'(s_cnt),       256'(cnt_s));
        check_eq("b_valid", 256'(b_out_valid), 256'(qb.size() > 0));
        check_eq("b_data",  256'(b_out_data),  256'(head_b()));
        check_eq("b_ready", 256'(b_in_ready),  256'((qb.size() == 0) || out_ready));
        check_eq("b_occ",   256'(b_occ),       256'(qb.size()));
        check_eq("b_cnt",   256'(b_cnt),       256'(cnt_b));
    endtask

    // One clock cycle: apply inputs, check settled outputs, advance the model.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic ordy,
                        input logic fl);
        bit push_a, pop_a, push_b, pop_b;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        compare_all();
        push_a = v && (qa.size() < 2);
        pop_a  = (qa.size() > 0) && ordy;
        push_b = v && ((qb.size() == 0) || ordy);
        pop_b  = (qb.size() > 0) && ordy;
        if (!fl && (qa.size() > 0) && !ordy) begin
            if (cnt_a < 65535) cnt_a++;
            if (cnt_s < 15) cnt_s++;
        end
        if (!fl && (qb.size() > 0) && !ordy && cnt_b < 65535) cnt_b++;
        if (fl) begin
            qa.delete();
            qb.delete();
        end else begin
            if (pop_a) void'(qa.pop_front());
            if (push_a) qa.push_back(d);
            if (pop_b) void'(qb.pop_front());
            if (push_b) qb.push_back(d);
        end
        @(posedge clk);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_clear();
        #12;
        compare_all();
        @(negedge clk);
        reset = 1'b1;

        // Streaming with downstream always ready.
        step(1'b1, 133'h11, 1'b1, 1'b0);
        step(1'b1, 133'h22, 1'b1, 1'b0);
        step(1'b1, 133'h33, 1'b1, 1'b0);
        step(1'b0, 133'h0,  1'b1, 1'b0);
        step(1'b0, 133'h0,  1'b1, 1'b0);

        // Back-pressure: 0xA, 0xB fill, 0xC held off, then release.
        step(1'b1, 133'hA, 1'b0, 1'b0);
        step(1'b1, 133'hB, 1'b0, 1'b0);
        step(1'b1, 133'hC, 1'b0, 1'b0);
        check_eq("bp_occ2",  256'(a_occ), 256'd2);
        check_eq("bp_noready", 256'(a_in_ready), 256'd0);
        step(1'b1, 133'hC, 1'b0, 1'b0);
        step(1'b1, 133'hC, 1'b1, 1'b0);
        step(1'b1, 133'hC, 1'b1, 1'b0);
        step(1'b0, 133'h0, 1'b1, 1'b0);
        step(1'b0, 133'h0, 1'b1, 1'b0);
        step(1'b0, 133'h0, 1'b1, 1'b0);

        // Flush with two held and a concurrent push of 0xD.
        step(1'b1, 133'h1, 1'b0, 1'b0);
        step(1'b1, 133'h2, 1'b0, 1'b0);
        step(1'b1, 133'hD, 1'b0, 1'b1);
        step(1'b0, 133'h0, 1'b1, 1'b0);
        check_eq("fl_valid", 256'(a_out_valid), 256'd0);
        check_eq("fl_occ",   256'(a_occ), 256'd0);

        // Single-entry replace: 0x5 held, then 0x6 pushed while draining.
        step(1'b1, 133'h5, 1'b0, 1'b0);
        step(1'b1, 133'h6, 1'b1, 1'b0);
        step(1'b0, 133'h0, 1'b0, 1'b0);
        check_eq("rep_data", 256'(b_out_data), 256'h6);
        check_eq("rep_occ",  256'(b_occ), 256'd1);

        // Asynchronous reset mid-stream with two beats held.
        step(1'b1, 133'h7, 1'b0, 1'b0);
        step(1'b0, 133'h0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        check_eq("rst_valid", 256'(a_out_valid), 256'd0);
        check_eq("rst_data",  256'(a_out_data), 256'd0);
        check_eq("rst_occ",   256'(a_occ), 256'd0);
        check_eq("rst_cnt",   256'(a_cnt), 256'd0);
        compare_all();
        @(negedge clk);
        reset = 1'b1;

        // Saturation of the 4-bit counter.
        step(1'b1, 133'h9, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 133'h0, 1'b0, 1'b0);
        #1;
        check_eq("sat15", 256'(s_cnt), 256'd15);
        check_eq("cnt20", 256'(a_cnt), 256'd20);
        for (int i = 0; i < 3; i++) step(1'b0, 133'h0, 1'b0, 1'b0);
        check_eq("sat_hold", 256'(s_cnt), 256'd15);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), rand_data(), 1'($urandom_range(0, 9) < 6),
                 1'($urandom_range(0, 19) == 0));
        end
        step(1'b0, 133'h0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
